alu: RTL and testbench

- Registered integer ALU for the datapath; one clock domain.
- Computes one of nine operations (ten with the optional multiply) on two WIDTH-bit operands, selected by a 4-bit control code.
- Produces the result plus ARM-style NZCV condition flags one clock after a valid request.
- Feeds the register-file write-back path and the condition/flag logic.

---
 rtl/alu.sv | 147 ++++++++++++++
 tb/tb_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu -- registered integer ALU with ARM-style NZCV condition flags.
//
// One request per clock and no stall. A request presented with in_valid=1 is
// visible on result/alu_flags one cycle later, with out_valid=1 in that cycle.
// When in_valid=0, result and alu_flags keep their last values and
// out_valid=0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low; clears result, flags and valid
//   in_valid   a/b/control carry a request this cycle
//   a, b       operands; the shift amount is the low $clog2(WIDTH) bits of b
//   control    operation select:
//                0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT
//                9 MUL (only when ALU_MUL_EN is defined), others give 0
//   result     registered result
//   alu_flags  registered flags {N, Z, C, V}
//   out_valid  result/alu_flags were updated this cycle
//
// Build option:
//   ALU_MUL_EN  when defined, control 1001 returns the low WIDTH bits of the
//               unsigned product a*b. When undefined, 1001 behaves like every
//               other unused code and no multiplier is built.
// ----------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags,
    output logic             out_valid
);

    localparam int SH_W = $clog2(WIDTH);

    logic        [SH_W-1:0]  sh;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    // Arithmetic is one bit wider so that carry and borrow fall out of the
    // top bit.
    logic        [WIDTH:0]   add_ext;
    logic        [WIDTH:0]   sub_ext;
    logic                    v_add;
    logic                    v_sub;
    logic                    slt_bit;

    // Shifts are also one bit wider. The extra bit catches the last bit
    // shifted out, and it stays 0 when sh == 0.
    logic        [WIDTH:0]   shl_ext;
    logic        [WIDTH:0]   shr_ext;
    logic signed [WIDTH:0]   sra_ext;

`ifdef ALU_MUL_EN
    logic        [WIDTH-1:0] mul_lo;
`endif

    logic        [WIDTH-1:0] res_p0;
    logic                    c_p0;
    logic                    v_p0;

    // N and Z are taken from the final result for every code.
    function automatic logic [1:0] nz_flags(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0)};
    endfunction

    assign sh  = b[SH_W-1:0];
    assign a_s = a;
    assign b_s = b;

    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} - {1'b0, b};
    assign v_add   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (add_ext[WIDTH-1] != a_s[WIDTH-1]);
    assign v_sub   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (sub_ext[WIDTH-1] != a_s[WIDTH-1]);
    // Signed less-than from the subtractor: the sign of a-b, corrected by
    // the overflow bit.
    assign slt_bit = sub_ext[WIDTH-1] ^ v_sub;

    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;
    assign sra_ext = $signed({a, 1'b0}) >>> sh;

`ifdef ALU_MUL_EN
    assign mul_lo = a * b;
`endif

    // Stage p0: combinational operation select
    always_comb begin
        res_p0 = '0;
        c_p0   = 1'b0;
        v_p0   = 1'b0;
        case (control)
            4'b0000: begin
                res_p0 = add_ext[WIDTH-1:0];
                c_p0   = add_ext[WIDTH];
                v_p0   = v_add;
            end
            4'b0001: begin
                res_p0 = sub_ext[WIDTH-1:0];
                c_p0   = ~sub_ext[WIDTH];
                v_p0   = v_sub;
            end
            4'b0010: res_p0 = a & b;
            4'b0011: res_p0 = a | b;
            4'b0100: res_p0 = a ^ b;
            4'b0101: begin
                res_p0 = shl_ext[WIDTH-1:0];
                c_p0   = shl_ext[WIDTH];
            end
            4'b0110: begin
                res_p0 = shr_ext[WIDTH:1];
                c_p0   = shr_ext[0];
            end
            4'b0111: begin
                res_p0 = sra_ext[WIDTH:1];
                c_p0   = sra_ext[0];
            end
            4'b1000: res_p0 = {{(WIDTH-1){1'b0}}, slt_bit};
`ifdef ALU_MUL_EN
            4'b1001: res_p0 = mul_lo;
`endif
            default: res_p0 = '0;
        endcase
    end

    // Stage p1: output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            alu_flags <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= res_p0;
                alu_flags <= {nz_flags(res_p0), c_p0, v_p0};
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu at WIDTH=32.
// The expected results come from a reference model that works on the
// operation definitions with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  control = '0;
    logic [31:0] result;
    logic [3:0]  alu_flags;
    logic        out_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: the outputs we expect after the most recent edge.
    logic [31:0] exp_r = '0;
    logic [3:0]  exp_f = '0;
    logic        exp_v = 1'b0;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .control(control), .result(result), .alu_flags(alu_flags),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic void ref_alu(input logic [31:0] x, input logic [31:0] y,
                                    input logic [3:0] c,
                                    output logic [31:0] r, output logic [3:0] f);
        longint unsigned xw, yw, wide;
        int   sh;
        logic cf, vf;
        xw = x; yw = y; wide = 0;
        sh = int'(y[4:0]);
        cf = 1'b0; vf = 1'b0; r = 32'd0;
        case (c)
            4'd0: begin
                wide = xw + yw;
                r  = wide[31:0];
                cf = wide[32];
                vf = (x[31] == y[31]) && (r[31] != x[31]);
            end
            4'd1: begin
                r  = x - y;
                cf = (x >= y);
                vf = (x[31] != y[31]) && (r[31] != x[31]);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: begin r = x << sh; cf = (sh != 0) ? x[32 - sh] : 1'b0; end
            4'd6: begin r = x >> sh; cf = (sh != 0) ? x[sh - 1] : 1'b0; end
            4'd7: begin r = $signed(x) >>> sh; cf = (sh != 0) ? x[sh - 1] : 1'b0; end
            4'd8: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'd9: begin wide = xw * yw; r = wide[31:0]; end
`endif
            default: r = 32'd0;
        endcase
        f = {r[31], (r == 32'd0), cf, vf};
    endfunction

    // Apply one cycle of inputs, advance the model and let the edge happen.
    task automatic drive(input logic rn, input logic v, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] c);
        logic [31:0] r;
        logic [3:0]  f;
        @(negedge clk);
        rst_n = rn; in_valid = v; a = x; b = y; control = c;
        ref_alu(x, y, c, r, f);
        if (!rn) begin
            exp_r = '0; exp_f = '0; exp_v = 1'b0;
        end else begin
            exp_v = v;
            if (v) begin exp_r = r; exp_f = f; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 32'd3, 32'd11, 4'd0);
        drive(1'b0, 1'b1, 32'd3, 32'd11, 4'd0);
        n_cmp++;
        if ({out_valid, alu_flags, result} !== {1'b0, 4'b0000, 32'd0}) begin
            n_err++;
            $display("FAIL reset: got v=%0b f=%b r=%h want v=0 f=0000 r=0", out_valid, alu_flags, result);
        end
        drive(1'b1, 1'b1, 32'd3, 32'd11, 4'd0);
        n_cmp++;
        if ({out_valid, alu_flags, result} !== {1'b1, 4'b0000, 32'd14}) begin
            n_err++;
            $display("FAIL reset_release: got v=%0b f=%b r=%h want v=1 f=0000 r=e", out_valid, alu_flags, result);
        end
    endtask

    task automatic test_op_table();
        logic [31:0] tr [9] = '{32'd14, 32'hFFFF_FFF8, 32'd3, 32'd11, 32'd8,
                                32'h1800, 32'd0, 32'd0, 32'd1};
        logic [3:0]  tf [9] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0100, 4'b0100, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 32'd3, 32'd11, 4'(i));
            n_cmp++;
            if ({out_valid, alu_flags, result} !== {1'b1, tf[i], tr[i]}) begin
                n_err++;
                $display("FAIL op_table[%0d]: got v=%0b f=%b r=%h want v=1 f=%b r=%h",
                         i, out_valid, alu_flags, result, tf[i], tr[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] ta [7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
                                32'h8000_0001, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] tb_ [7] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'd1, 32'd32};
        logic [3:0]  tc [7] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd7, 4'd5, 4'd5};
        logic [31:0] tr [7] = '{32'h8000_0000, 32'd0, 32'd0, 32'h7FFF_FFFF,
                                32'hC000_0000, 32'd0, 32'h1234_5678};
        logic [3:0]  tf [7] = '{4'b1001, 4'b0110, 4'b0110, 4'b0011,
                                4'b1010, 4'b0110, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, ta[i], tb_[i], tc[i]);
            n_cmp++;
            if ({out_valid, alu_flags, result} !== {1'b1, tf[i], tr[i]}) begin
                n_err++;
                $display("FAIL boundary[%0d]: got v=%0b f=%b r=%h want v=1 f=%b r=%h",
                         i, out_valid, alu_flags, result, tf[i], tr[i]);
            end
        end
    endtask

    task automatic test_hold_undef();
        logic [31:0] held_r;
        logic [3:0]  held_f;
        drive(1'b1, 1'b1, 32'h8000_0000, 32'd1, 4'd1);
        held_r = 32'h7FFF_FFFF;
        held_f = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
            n_cmp++;
            if ({out_valid, alu_flags, result} !== {1'b0, held_f, held_r}) begin
                n_err++;
                $display("FAIL hold[%0d]: got v=%0b f=%b r=%h want v=0 f=%b r=%h",
                         i, out_valid, alu_flags, result, held_f, held_r);
            end
        end
        drive(1'b1, 1'b1, 32'd3, 32'd11, 4'b1111);
        n_cmp++;
        if ({out_valid, alu_flags, result} !== {1'b1, 4'b0100, 32'd0}) begin
            n_err++;
            $display("FAIL undef_1111: got v=%0b f=%b r=%h want v=1 f=0100 r=0", out_valid, alu_flags, result);
        end
        drive(1'b1, 1'b1, 32'd3, 32'd11, 4'b1001);
`ifdef ALU_MUL_EN
        held_r = 32'd33; held_f = 4'b0000;
`else
        held_r = 32'd0;  held_f = 4'b0100;
`endif
        n_cmp++;
        if ({out_valid, alu_flags, result} !== {1'b1, held_f, held_r}) begin
            n_err++;
            $display("FAIL code_1001: got v=%0b f=%b r=%h want v=1 f=%b r=%h",
                     out_valid, alu_flags, result, held_f, held_r);
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 600; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: x = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                1: y = x;
                2: y = 32'($urandom_range(0, 63));
                default: ;
            endcase
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                  x, y, 4'($urandom_range(0, 15)));
            n_cmp++;
            if ({out_valid, alu_flags, result} !== {exp_v, exp_f, exp_r}) begin
                n_err++;
                $display("FAIL random[%0d]: a=%h b=%h c=%0d got v=%0b f=%b r=%h want v=%0b f=%b r=%h",
                         i, x, y, control, out_valid, alu_flags, result, exp_v, exp_f, exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_op_table();
        test_boundaries();
        test_hold_undef();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
